// File: rtl/ram_bank_arb_wrap_pkg.sv
// Shared constants and width helpers for the banked RAM arbiter wrapper.
package ram_bank_arb_wrap_pkg;

   localparam int DEF_DATA_WIDTH = 28;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_BANK_BIT   = 2;
   localparam int DEF_SEG_WIDTH  = 7;
   localparam int DEF_CNT_WIDTH  = 16;

   function automatic int mask_width(input int dw, input int sw);
      return dw / sw;
   endfunction

   function automatic int row_width(input int aw, input int bb);
      return aw - bb;
   endfunction

endpackage

// File: rtl/ram_bank_arb_wrap_sp.sv
// Single-port bank: segment-masked write, registered read; a write blocks the read.
module ram_bank_sp
   import ram_bank_arb_wrap_pkg::*;
#(
   parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int  SEG_WIDTH  = DEF_SEG_WIDTH,
   parameter int  ROW_WIDTH  = DEF_ADDR_WIDTH - DEF_BANK_BIT,
   localparam int MASK_WIDTH = mask_width(DATA_WIDTH, SEG_WIDTH),
   localparam int DEPTH      = 2**ROW_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ROW_WIDTH-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [MASK_WIDTH-1:0] wmask_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Contents are deliberately never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int s = 0; s < MASK_WIDTH; s++) begin
            if (wmask_i[s]) mem_q[addr_i][s*SEG_WIDTH +: SEG_WIDTH] <= wdata_i[s*SEG_WIDTH +: SEG_WIDTH];
         end
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank_arb_wrap.sv
// Interleaved multi-bank RAM: writes always win a bank, a conflicting read waits
// in a single pending slot; read results are held between valid pulses.
module ram_bank_arb_wrap
   import ram_bank_arb_wrap_pkg::*;
#(
   parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int  BANK_BIT   = DEF_BANK_BIT,
   parameter int  SEG_WIDTH  = DEF_SEG_WIDTH,
   parameter int  CNT_WIDTH  = DEF_CNT_WIDTH,
   localparam int MASK_WIDTH = mask_width(DATA_WIDTH, SEG_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [MASK_WIDTH-1:0] wr_mask_i,
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic                  rd_gnt_o,
   output logic                  rd_valid_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

   localparam int NUM_BANK = 2**BANK_BIT;
   localparam int ROW_W    = row_width(ADDR_WIDTH, BANK_BIT);

   logic                  wr_act, conflict, iss_vld;
   logic [ADDR_WIDTH-1:0] iss_addr;
   logic                  pend_vld_q, pend_vld_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  rvld_q;
   logic [BANK_BIT-1:0]   rbank_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [NUM_BANK-1:0][DATA_WIDTH-1:0] bank_rdata;

   always_comb begin
      wr_act      = wr_en_i & ~rst_i;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      iss_vld     = 1'b0;
      iss_addr    = pend_addr_q;
      conflict    = 1'b0;
      // The pending read goes first; new reads are refused while it waits.
      if (pend_vld_q) begin
         if (wr_act && (wr_addr_i[BANK_BIT-1:0] == pend_addr_q[BANK_BIT-1:0])) begin
            conflict = 1'b1;
         end else begin
            iss_vld    = 1'b1;
            pend_vld_d = 1'b0;
         end
      end else if (rd_req_i) begin
         if (wr_act && (wr_addr_i[BANK_BIT-1:0] == rd_addr_i[BANK_BIT-1:0])) begin
            conflict    = 1'b1;
            pend_vld_d  = 1'b1;
            pend_addr_d = rd_addr_i;
         end else begin
            iss_vld  = 1'b1;
            iss_addr = rd_addr_i;
         end
      end
      cnt_d = (conflict && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         cnt_q       <= '0;
         rvld_q      <= 1'b0;
         rbank_q     <= '0;
         hold_q      <= '0;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         cnt_q       <= cnt_d;
         rvld_q      <= iss_vld;
         if (iss_vld) rbank_q <= iss_addr[BANK_BIT-1:0];
         if (rvld_q)  hold_q  <= bank_rdata[rbank_q];
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic             bank_we, bank_re;
      logic [ROW_W-1:0] bank_addr;
      assign bank_we   = wr_act && (wr_addr_i[BANK_BIT-1:0] == BANK_BIT'(b));
      assign bank_re   = iss_vld && (iss_addr[BANK_BIT-1:0] == BANK_BIT'(b));
      assign bank_addr = bank_we ? wr_addr_i[ADDR_WIDTH-1:BANK_BIT] : iss_addr[ADDR_WIDTH-1:BANK_BIT];

      ram_bank_sp #(
         .DATA_WIDTH (DATA_WIDTH),
         .SEG_WIDTH  (SEG_WIDTH),
         .ROW_WIDTH  (ROW_W)
      ) u_bank (
         .clk_i   (clk_i),
         .we_i    (bank_we),
         .re_i    (bank_re),
         .addr_i  (bank_addr),
         .wdata_i (wr_data_i),
         .wmask_i (wr_mask_i),
         .rdata_o (bank_rdata[b])
      );
   end

   assign rd_gnt_o       = ~pend_vld_q;
   assign rd_valid_o     = rvld_q;
   assign rd_data_o      = rvld_q ? bank_rdata[rbank_q] : hold_q;
   assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_ram_bank_arb_wrap.sv
// Scoreboard bench: a cycle-level reference model queues expected read data,
// a negedge monitor checks grant, counter, valid timing and returned data.
module tb_ram_bank_arb_wrap;

   localparam int DW = 28, AW = 8, BB = 2, SW = 7, CW = 3;
   localparam int MW = DW / SW, NB = 1 << BB, CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1, wr_en = 1'b0, rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [MW-1:0] wr_mask = '0;
   logic          rd_gnt, rd_valid;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] conflict_cnt;

   int n_checks = 0, n_errors = 0;

   logic [DW-1:0] mem [1 << AW];
   logic [DW-1:0] exp_q [$];
   bit            m_pend = 0, m_valid = 0;
   logic [AW-1:0] m_paddr = '0;
   int            m_cnt = 0;
   logic [DW-1:0] m_vdata = '0, m_hold = '0;
   bit            mon_en = 0;

   ram_bank_arb_wrap #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BIT(BB), .SEG_WIDTH(SW), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_mask_i(wr_mask), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
      .rd_valid_o(rd_valid), .rd_data_o(rd_data), .conflict_cnt_o(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what one clock edge does given the inputs held during the cycle.
   task automatic model_step();
      int wb;
      bit issue;
      logic [AW-1:0] ia;
      if (rst) begin
         m_pend = 0; m_cnt = 0; m_valid = 0; m_hold = '0;
         exp_q.delete();
         return;
      end
      if (m_valid) m_hold = m_vdata;
      m_valid = 0;
      issue = 0;
      ia = '0;
      wb = int'(wr_addr) % NB;
      if (m_pend) begin
         if (wr_en && wb == int'(m_paddr) % NB) begin
            if (m_cnt < CMAX) m_cnt++;
         end else begin
            issue = 1; ia = m_paddr; m_pend = 0;
         end
      end else if (rd_req) begin
         if (wr_en && wb == int'(rd_addr) % NB) begin
            m_pend = 1; m_paddr = rd_addr;
            if (m_cnt < CMAX) m_cnt++;
         end else begin
            issue = 1; ia = rd_addr;
         end
      end
      if (issue) begin
         m_valid = 1;
         m_vdata = mem[ia];
         exp_q.push_back(m_vdata);
      end
      if (wr_en) begin
         for (int s = 0; s < MW; s++)
            if (wr_mask[s]) mem[wr_addr][s*SW +: SW] = wr_data[s*SW +: SW];
      end
   endtask

   task automatic step(input bit r, input bit we, input int wa, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm, input bit rq, input int ra);
      rst = r; wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_mask = wm;
      rd_req = rq; rd_addr = AW'(ra);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rd_gnt", 32'(rd_gnt), 32'(!m_pend));
         chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
         chk("rd_valid", 32'(rd_valid), 32'(m_valid));
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL rd_data: unexpected rd_valid, data %h", rd_data);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
         end else begin
            chk("rd_hold", 32'(rd_data), 32'(m_hold));
         end
      end
   end

   localparam logic [MW-1:0] ALL = '1;

   initial begin
      step(1, 0, 0, '0, '0, 0, 0);
      step(1, 0, 0, '0, '0, 0, 0);
      mon_en = 1;
      @(negedge clk);
      chk("reset_gnt", 32'(rd_gnt), 32'd1);
      chk("reset_valid", 32'(rd_valid), 32'd0);
      chk("reset_data", 32'(rd_data), 32'd0);
      chk("reset_cnt", 32'(conflict_cnt), 32'd0);

      for (int a = 0; a < (1 << AW); a++) step(0, 1, a, DW'($urandom), ALL, 0, 0);

      // Write then read the same address next cycle.
      step(0, 1, 5, 28'hABCDEF1, ALL, 0, 0);
      step(0, 0, 0, '0, '0, 1, 5);
      @(negedge clk);
      chk("wr_rd_valid", 32'(rd_valid), 32'd1);
      chk("wr_rd_data", 32'(rd_data), 32'h0ABCDEF1);
      chk("wr_rd_cnt", 32'(conflict_cnt), 32'd0);

      // Same-bank write and read: read pends one cycle.
      step(0, 1, 4, DW'($urandom), ALL, 1, 8);
      @(negedge clk);
      chk("pend_gnt", 32'(rd_gnt), 32'd0);
      chk("pend_valid_early", 32'(rd_valid), 32'd0);
      idle();
      @(negedge clk);
      chk("pend_valid", 32'(rd_valid), 32'd1);
      chk("pend_cnt", 32'(conflict_cnt), 32'd1);

      // Different banks: no conflict.
      step(0, 1, 1, DW'($urandom), ALL, 1, 2);
      @(negedge clk);
      chk("nocfl_valid", 32'(rd_valid), 32'd1);
      chk("nocfl_cnt", 32'(conflict_cnt), 32'd1);

      // Masked merge.
      step(0, 1, 3, '0, ALL, 0, 0);
      step(0, 1, 3, 28'hFFFFFFF, 4'b0101, 0, 0);
      step(0, 0, 0, '0, '0, 1, 3);
      @(negedge clk);
      chk("mask_data", 32'(rd_data), 32'h001FC07F);

      // Read blocked three cycles, then counter saturation.
      step(1, 0, 0, '0, '0, 0, 0);
      step(0, 1, 0, DW'($urandom), ALL, 1, 4);
      step(0, 1, 8, DW'($urandom), ALL, 0, 0);
      step(0, 1, 12, DW'($urandom), ALL, 0, 0);
      idle();
      @(negedge clk);
      chk("block3_valid", 32'(rd_valid), 32'd1);
      chk("block3_cnt", 32'(conflict_cnt), 32'd3);
      step(0, 1, 0, DW'($urandom), ALL, 1, 4);
      for (int i = 0; i < 4; i++) step(0, 1, 0, DW'($urandom), ALL, 0, 0);
      idle();
      @(negedge clk);
      chk("sat_cnt", 32'(conflict_cnt), 32'(CMAX));

      // Reset while a read is pending.
      step(0, 1, 0, DW'($urandom), ALL, 1, 4);
      step(1, 0, 0, '0, '0, 0, 0);
      @(negedge clk);
      chk("rst_pend_valid", 32'(rd_valid), 32'd0);
      chk("rst_pend_gnt", 32'(rd_gnt), 32'd1);
      chk("rst_pend_cnt", 32'(conflict_cnt), 32'd0);
      idle();
      @(negedge clk);
      chk("rst_pend_valid2", 32'(rd_valid), 32'd0);

      // Writes during reset are ignored.
      step(1, 1, 9, 28'h1234567, ALL, 0, 0);
      step(0, 0, 0, '0, '0, 1, 9);
      idle();

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 255),
              DW'($urandom), MW'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 255));

      for (int i = 0; i < 4; i++) idle();
      @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
